// File: rtl/stream_cipher_ctrl.sv
// stream_cipher_ctrl: seeds, warms up and steps an external LFSR keystream generator,
// XORing its output onto a valid/ready byte stream through a one-stage output register.
module stream_cipher_ctrl #(
    parameter int WARMUP = 4,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       seed,
    input  logic [LEN_W-1:0] msg_len,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             prng_load_seed,
    output logic [7:0]       prng_seed,
    output logic             prng_encrypt_en,
    input  logic [7:0]       prng_value
);
    typedef enum logic [2:0] {IDLE, LOAD, WARM, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [7:0]       seed_r;
    logic [7:0]       warm_cnt;
    logic [LEN_W-1:0] remaining;
    logic             accept;
    logic             fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (msg_len != '0) ? LOAD : DONE;
            LOAD:    state_nx = (WARMUP > 0) ? WARM : RUN;
            WARM:    if (warm_cnt == 8'd1) state_nx = RUN;
            RUN:     if (remaining == '0 && (!out_valid || fire)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // in_ready is combinational so a draining output slot can be refilled in the same cycle
    always_comb begin
        busy            = state != IDLE;
        done            = state == DONE;
        in_ready        = state == RUN && remaining != '0 && (!out_valid || out_ready);
        accept          = in_valid && in_ready;
        fire            = out_valid && out_ready;
        prng_load_seed  = state == LOAD;
        prng_seed       = seed_r;
        prng_encrypt_en = state == WARM || accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_r    <= '0;
            remaining <= '0;
            warm_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (state == IDLE && start) begin
                seed_r    <= seed;
                remaining <= msg_len;
            end
            if (state == LOAD) warm_cnt <= 8'(WARMUP);
            if (state == WARM) warm_cnt <= warm_cnt - 8'd1;
            if (accept) begin
                out_data  <= in_data ^ prng_value;
                remaining <= remaining - LEN_W'(1);
            end
            if (accept)    out_valid <= 1'b1;
            else if (fire) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_cipher_ctrl.sv
// tb_stream_cipher_ctrl: random and directed streams scored against a keystream model
// computed straight from the LFSR definition (seed stepped WARMUP+k times for byte k).
module tb_stream_cipher_ctrl;
    localparam int WARMUP = 4;
    localparam int LEN_W = 16;
    typedef logic [7:0] bq_t[$];

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [7:0]       seed = 8'h00;
    logic [LEN_W-1:0] msg_len = '0;
    logic             busy, done, in_ready, out_valid;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data, prng_seed;
    logic             prng_load_seed, prng_encrypt_en;
    logic [7:0]       gen_q = 8'h00;

    int   vectors = 0, errors = 0, cyc = 0;
    bq_t  src_q, exp_q, out_log, q;
    logic [7:0] msg_seed = 8'h00, stall_data = 8'h00, stall_first = 8'h00;
    int   acc_idx = 0, n_done = 0, n_load = 0, n_stall = 0, bp_cnt = 0, bp_mode = 0, gap_en = 0;
    int   start_cyc = 0, first_rdy = -1, first_fire = -1, last_fire = -1, done_cyc = -1;
    logic acc = 1'b0, stalled = 1'b0;

    stream_cipher_ctrl #(.WARMUP(WARMUP), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .msg_len(msg_len),
        .busy(busy), .done(done), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .prng_load_seed(prng_load_seed), .prng_seed(prng_seed),
        .prng_encrypt_en(prng_encrypt_en), .prng_value(gen_q)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] ks(input logic [7:0] s, input int n);
        logic [7:0] v = s;
        for (int i = 0; i < n; i++) v = step(v);
        return v;
    endfunction

    // the external keystream generator the controller drives
    always @(posedge clk) begin
        if (prng_load_seed)       gen_q <= prng_seed;
        else if (prng_encrypt_en) gen_q <= step(gen_q);
    end

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void chk_log(input string name, input bq_t e);
        chk({name, "_count"}, out_log.size(), e.size());
        for (int i = 0; i < e.size() && i < out_log.size(); i++) chk(name, int'(out_log[i]), int'(e[i]));
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (stalled) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), int'(stall_data));
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", int'(in_ready), 0);
                chk("stall_advance", int'(prng_encrypt_en), 0);
                if (n_stall == 0) stall_first = out_data;
                n_stall++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious_out", 1, 0);
                else chk("out_data", int'(out_data), int'(exp_q.pop_front()));
                out_log.push_back(out_data);
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back(in_data ^ ks(msg_seed, WARMUP + acc_idx));
                acc_idx++;
            end
            if (start && !busy) start_cyc = cyc;
            if (in_ready && first_rdy < 0) first_rdy = cyc;
            if (prng_load_seed) n_load++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
                chk("done_busy", int'(busy), 1);
            end
            stalled = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    always @(posedge clk) begin
        #1;
        if (acc && src_q.size() > 0) void'(src_q.pop_front());
        in_valid = src_q.size() > 0 && (gap_en == 0 || $urandom_range(0, 3) != 0);
        in_data = src_q.size() > 0 ? src_q[0] : 8'h00;
        if (acc_idx > 0) bp_cnt++;
        out_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? ($urandom_range(0, 2) != 0) : !(acc_idx > 0 && bp_cnt <= 5);
    end

    task automatic arm(input logic [7:0] s, input bq_t d);
        msg_seed = s; acc_idx = 0; n_done = 0; n_load = 0; n_stall = 0; bp_cnt = 0;
        first_rdy = -1; first_fire = -1; last_fire = -1; done_cyc = -1;
        out_log.delete(); exp_q.delete();
        src_q = d;
    endtask

    task automatic msg(input logic [7:0] s, input int len, input bq_t d, input bit spam);
        arm(s, d);
        @(posedge clk); #2;
        start = 1'b1; seed = s; msg_len = LEN_W'(len);
        @(posedge clk); #2;
        start = spam; seed = 8'h55; msg_len = LEN_W'(7);
        for (int i = 0; i < 1000 && n_done == 0; i++) begin
            @(posedge clk); #2;
            if (i == 6) start = 1'b0;
        end
        start = 1'b0;
        chk("timeout", int'(n_done > 0), 1);
        repeat (3) @(posedge clk);
        #2;
        chk("done_count", n_done, 1);
        chk("out_count", out_log.size(), len);
        chk("busy_after", int'(busy), 0);
        chk("leftover", exp_q.size(), 0);
        if (len > 0) chk("done_after_fire", done_cyc, last_fire + 1);
        else begin
            chk("zero_done_lat", done_cyc, start_cyc + 1);
            chk("zero_no_load", n_load, 0);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_in_ready"}, int'(in_ready), 0);
        chk({name, "_out_valid"}, int'(out_valid), 0);
        chk({name, "_out_data"}, int'(out_data), 0);
        chk({name, "_load"}, int'(prng_load_seed), 0);
        chk({name, "_seed"}, int'(prng_seed), 0);
        chk({name, "_en"}, int'(prng_encrypt_en), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #2;
        rst = 1'b0;
        chk("model_ks0", int'(ks(8'h01, 4)), 8'h11);
        chk("model_ks2", int'(ks(8'h01, 6)), 8'h47);

        q = {8'h00, 8'h00, 8'h00};
        msg(8'h01, 3, q, 1'b0);
        q = {8'h11, 8'h23, 8'h47};
        chk_log("enc", q);
        chk("first_ready_lat", first_rdy - start_cyc, 2 + WARMUP);
        chk("stream_span", last_fire - first_fire, 2);

        msg(8'h01, 3, q, 1'b0);
        q = {8'h00, 8'h00, 8'h00};
        chk_log("dec", q);
        q = {8'hFF, 8'hFF};
        msg(8'h01, 2, q, 1'b0);
        q = {8'hEE, 8'hDC};
        chk_log("dec_ff", q);

        bp_mode = 2;
        q = {8'h00, 8'h00, 8'h00};
        msg(8'h01, 3, q, 1'b0);
        bp_mode = 0;
        q = {8'h11, 8'h23, 8'h47};
        chk_log("bp", q);
        chk("bp_stall_cycles", n_stall, 5);
        chk("bp_held", int'(stall_first), 8'h11);

        q.delete();
        msg(8'h2C, 0, q, 1'b0);

        q = {8'h00, 8'h00, 8'h00};
        msg(8'h01, 3, q, 1'b1);
        q = {8'h11, 8'h23, 8'h47};
        chk_log("ign_start", q);

        q = {8'h00, 8'h00, 8'h00};
        arm(8'h01, q);
        @(posedge clk); #2;
        start = 1'b1; seed = 8'h01; msg_len = LEN_W'(3);
        @(posedge clk); #2;
        start = 1'b0;
        for (int i = 0; i < 50 && acc_idx == 0; i++) @(posedge clk);
        chk("rst_reach_run", int'(acc_idx > 0), 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        src_q.delete(); exp_q.delete(); acc = 1'b0; stalled = 1'b0; acc_idx = 0;
        @(posedge clk); #2;
        rst = 1'b0;
        q = {8'h00};
        msg(8'h01, 1, q, 1'b0);
        q = {8'h11};
        chk_log("after_rst", q);

        bp_mode = 1; gap_en = 1;
        for (int m = 0; m < 25; m++) begin
            int len;
            logic [7:0] s;
            len = $urandom_range(0, 12);
            s = 8'($urandom);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            msg(s, len, q, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/stream_cipher_ctrl.md
Name: stream_cipher_ctrl

Overview:
Sequencing controller for the 8-bit LFSR keystream generator (taps 7,5,4,3, shift-left, feedback into bit 0) in the stream-cipher datapath. Per message it loads a seed, discards a fixed number of warm-up keystream bytes, then XORs each accepted plaintext/ciphertext byte with the current keystream byte and advances the generator exactly once per byte. It sits between a byte-stream source and sink using valid/ready handshakes and drives the generator's load_seed, seed_in and encrypt_en inputs.

Parameters:
WARMUP, 4, number of keystream steps discarded after seed load (0 allowed; 0..255)
LEN_W, 16, width of message length field

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin message; sampled only in IDLE
seed  input  8  seed captured on accepted start
msg_len  input  LEN_W  byte count captured on accepted start
busy  output  1  high when state != IDLE
done  output  1  high for exactly the one cycle spent in DONE
in_valid  input  1  input byte valid
in_data  input  8  input byte
in_ready  output  1  controller accepts input byte
out_valid  output  1  output byte valid
out_data  output  8  in_data XOR keystream
out_ready  input  1  sink accepts output byte
prng_load_seed  output  1  to generator load_seed
prng_seed  output  8  to generator seed_in
prng_encrypt_en  output  1  to generator encrypt_en
prng_value  input  8  generator current output

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, in_ready, out_valid, prng_load_seed, prng_encrypt_en = 0; out_data, prng_seed, counters = 0. Generator is not touched; it is reseeded on the next start.
- States: IDLE, LOAD, WARM, RUN, DONE.
- IDLE: start=1 captures seed and msg_len. msg_len!=0 -> LOAD; msg_len==0 -> DONE. start in any other state is ignored.
- LOAD (1 cycle): prng_load_seed=1, prng_seed=captured seed. Next state: WARM if WARMUP>0, else RUN.
- WARM: prng_encrypt_en=1 for exactly WARMUP consecutive cycles (down-counter), then RUN. in_ready=0 throughout.
- RUN: single-stage output register.
  - in_ready = (remaining!=0) && (!out_valid || out_ready) — combinational.
  - Accept = in_valid && in_ready. On accept: out_data <= in_data ^ prng_value; out_valid <= 1; remaining--. prng_encrypt_en = accept, combinationally in the same cycle, so the generator advances once per accepted byte.
  - Output fire = out_valid && out_ready. Fire without accept: out_valid <= 0. Fire and accept in the same cycle: out_valid stays 1 with the new byte, giving full throughput of 1 byte/cycle.
  - out_data is held stable while out_valid && !out_ready.
  - Exit: remaining==0 && (!out_valid || fire) -> DONE, so DONE follows the final output fire.
- DONE (1 cycle): done=1, busy=1; -> IDLE.
- Reset mid-operation aborts immediately; a partial output byte is dropped.
- Latency: first input accept is at start+2+WARMUP cycles at the earliest. Output is valid the cycle after accept.
- Decrypt is identical to encrypt for the same seed.

Test Plan:
- Seed 0x01, WARMUP=4, msg_len=3, in_data 0x00,0x00,0x00 streamed with out_ready=1 -> out_data 0x11,0x23,0x47 on consecutive cycles; done pulses 1 cycle after the third fire; busy falls with it.
- Decrypt: seed 0x01, msg_len=3, in_data 0x11,0x23,0x47 -> out 0x00,0x00,0x00. Input 0xFF,0xFF -> 0xEE,0xDC.
- Backpressure: seed 0x01, out_ready=0 after the first accept -> out_data holds 0x11, in_ready=0, prng_encrypt_en=0 for all stalled cycles. Releasing out_ready yields 0x23 next, with no keystream skipped.
- msg_len=0 with start -> no LOAD, prng_load_seed never asserts, done=1 on the cycle after start.
- start asserted during WARM/RUN with seed 0x55 -> ignored; stream still matches seed 0x01 values.
- rst asserted mid-RUN after 1 of 3 bytes -> all outputs 0 asynchronously, state IDLE. A new start with seed 0x01, msg_len=1 produces 0x11.
